// File: rtl/tdm_demux.sv
// ============================================================================
// Module   : tdm_demux
// Brief    : TDM receive demultiplexer with sync-flag frame lock, alignment
//            error reporting, per-channel strobes and held channel registers.
//            Define TDM_DEMUX_FRAME_BUF_EN for whole-frame (shadowed) updates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_sync,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    output logic                      frame_done,
    output logic                      locked,
    output logic                      sync_err
);

    localparam int                c_CHAN_W = $clog2(CHANNELS);
    localparam logic [c_CHAN_W-1:0] c_CHAN_LAST = c_CHAN_W'(CHANNELS - 1);
    localparam logic [c_CHAN_W-1:0] c_CHAN_ZERO = '0;
    localparam logic [c_CHAN_W-1:0] c_CHAN_ONE  = c_CHAN_W'(1);

    localparam logic [0:0] c_ST_HUNT   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    logic [0:0]                r_state;
    logic [c_CHAN_W-1:0]       r_chan;
    logic [CHANNELS*WIDTH-1:0] r_out_data;
    logic [CHANNELS-1:0]       r_out_valid;
    logic                      r_frame_done;
    logic                      r_sync_err;

    // Channel-0 writes happen on any accepted sync; the rest only in-frame.
    logic w_take_sync;
    logic w_take_data;
    logic w_last_word;
    logic w_early_sync;
    logic w_missing_sync;

    always_comb begin
        w_take_sync    = in_valid && in_sync;
        w_take_data    = in_valid && !in_sync && (r_state == c_ST_LOCKED) &&
                         (r_chan != c_CHAN_ZERO);
        w_last_word    = w_take_data && (r_chan == c_CHAN_LAST);
        w_early_sync   = w_take_sync && (r_state == c_ST_LOCKED) &&
                         (r_chan != c_CHAN_ZERO);
        w_missing_sync = in_valid && !in_sync && (r_state == c_ST_LOCKED) &&
                         (r_chan == c_CHAN_ZERO);
    end

`ifdef TDM_DEMUX_FRAME_BUF_EN
    logic [CHANNELS*WIDTH-1:0] r_shadow;
    logic [CHANNELS*WIDTH-1:0] w_frame_next;

    // The completed frame includes the word arriving this cycle.
    always_comb begin
        w_frame_next = r_shadow;
        w_frame_next[r_chan*WIDTH +: WIDTH] = in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow    <= '0;
            r_out_data  <= '0;
            r_out_valid <= '0;
        end else begin
            r_out_valid <= '0;
            if (w_take_sync) begin
                r_shadow[0 +: WIDTH] <= in_data;
            end else if (w_take_data) begin
                r_shadow[r_chan*WIDTH +: WIDTH] <= in_data;
                if (w_last_word) begin
                    r_out_data  <= w_frame_next;
                    r_out_valid <= {CHANNELS{1'b1}};
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= '0;
        end else begin
            r_out_valid <= '0;
            if (w_take_sync) begin
                r_out_data[0 +: WIDTH] <= in_data;
                r_out_valid[0]         <= 1'b1;
            end else if (w_take_data) begin
                r_out_data[r_chan*WIDTH +: WIDTH] <= in_data;
                r_out_valid[r_chan]               <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_HUNT;
            r_chan       <= c_CHAN_ZERO;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_frame_done <= w_last_word;
            r_sync_err   <= w_early_sync || w_missing_sync;
            if (w_take_sync) begin
                r_state <= c_ST_LOCKED;
                r_chan  <= c_CHAN_ONE;
            end else if (w_missing_sync) begin
                r_state <= c_ST_HUNT;
                r_chan  <= c_CHAN_ZERO;
            end else if (w_take_data) begin
                r_chan <= w_last_word ? c_CHAN_ZERO : r_chan + c_CHAN_ONE;
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;
    assign locked     = (r_state == c_ST_LOCKED);
    assign sync_err   = r_sync_err;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux.sv
// ============================================================================
// Module   : tb_tdm_demux
// Brief    : Self-checking bench for tdm_demux: directed frames plus random
//            traffic compared against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux;

    localparam int W  = 8;
    localparam int CH = 4;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [W-1:0]    in_data;
    logic            in_sync;
    logic [CH*W-1:0] out_data;
    logic [CH-1:0]   out_valid;
    logic            frame_done;
    logic            locked;
    logic            sync_err;

    tdm_demux #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sync    (in_sync),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference model: frame position as a plain integer, channel words as an array.
    int          m_out [CH];
    int          m_buf [CH];
    bit          m_locked;
    int          m_pos;
    logic [CH-1:0] e_valid;
    bit          e_done;
    bit          e_err;

    task automatic model_write(input int k, input int d);
`ifdef TDM_DEMUX_FRAME_BUF_EN
        m_buf[k] = d;
`else
        m_out[k] = d;
        e_valid[k] = 1'b1;
`endif
    endtask

    task automatic model_step(input bit r, input bit v, input bit s, input int d);
        e_valid = '0;
        e_done  = 0;
        e_err   = 0;
        if (r) begin
            for (int k = 0; k < CH; k++) begin
                m_out[k] = 0;
                m_buf[k] = 0;
            end
            m_locked = 0;
            m_pos    = 0;
        end else if (v) begin
            if (s) begin
                if (m_locked && m_pos != 0) e_err = 1;
                model_write(0, d);
                m_pos    = 1;
                m_locked = 1;
            end else if (m_locked && m_pos == 0) begin
                e_err    = 1;
                m_locked = 0;
            end else if (m_locked) begin
                model_write(m_pos, d);
                if (m_pos == CH - 1) begin
                    e_done = 1;
                    m_pos  = 0;
`ifdef TDM_DEMUX_FRAME_BUF_EN
                    for (int k = 0; k < CH; k++) m_out[k] = m_buf[k];
                    e_valid = '1;
`endif
                end else begin
                    m_pos = m_pos + 1;
                end
            end
        end
    endtask

    function automatic logic [CH*W-1:0] model_data();
        logic [CH*W-1:0] v;
        for (int k = 0; k < CH; k++) v[k*W +: W] = m_out[k][W-1:0];
        return v;
    endfunction

    task automatic cyc(input bit r, input bit v, input bit s, input logic [W-1:0] d);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_sync  = s;
        in_data  = d;
        @(posedge clk);
        model_step(r, v, s, int'(d));
        #1;
        check_val("out_data",   64'(out_data),   64'(model_data()));
        check_val("out_valid",  64'(out_valid),  64'(e_valid));
        check_val("frame_done", 64'(frame_done), 64'(e_done));
        check_val("locked",     64'(locked),     64'(m_locked));
        check_val("sync_err",   64'(sync_err),   64'(e_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, W'($urandom));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sync = 1'b0; in_data = '0;
        cyc(1, 0, 0, 8'h00);
        cyc(1, 1, 1, 8'hEE);
        check_val("reset_data", 64'(out_data), 64'h0);

        // Basic frame
        cyc(0, 1, 1, 8'h11); cyc(0, 1, 0, 8'h22);
        cyc(0, 1, 0, 8'h33); cyc(0, 1, 0, 8'h44);
        check_val("basic_frame", 64'(out_data), 64'h44332211);
        check_val("basic_done", 64'(frame_done), 64'h1);

        // Hunt discard
        cyc(1, 0, 0, 8'h00);
        cyc(0, 1, 0, 8'hAA); cyc(0, 1, 0, 8'hBB);
        check_val("hunt_nolock", 64'(locked), 64'h0);
        cyc(0, 1, 1, 8'h11);
        check_val("hunt_ch0", 64'(out_data[7:0]), 64'h11);

        // Early sync, then next word lands on channel 1
        cyc(0, 1, 0, 8'h22);
        cyc(0, 1, 1, 8'h55);
        check_val("early_err", 64'(sync_err), 64'h1);
        cyc(0, 1, 0, 8'h77);
`ifndef TDM_DEMUX_FRAME_BUF_EN
        check_val("early_ch1", 64'(out_valid), 64'h2);
`endif
        cyc(0, 1, 0, 8'h33); cyc(0, 1, 0, 8'h44);

        // Missing sync after a completed frame
        cyc(0, 1, 0, 8'h66);
        check_val("missing_err", 64'(sync_err), 64'h1);
        idle(1);
        check_val("missing_unlock", 64'(locked), 64'h0);

        // Gapped frame, then reset mid-frame
        cyc(1, 0, 0, 8'h00);
        cyc(0, 1, 1, 8'h11); idle(3);
        cyc(0, 1, 0, 8'h22); idle(3);
        cyc(0, 1, 0, 8'h33); idle(3);
        cyc(0, 1, 0, 8'h44);
        check_val("gap_frame", 64'(out_data), 64'h44332211);
        cyc(0, 1, 1, 8'h91); cyc(0, 1, 0, 8'h92);
        cyc(1, 1, 0, 8'h93);
        check_val("rst_mid_data", 64'(out_data), 64'h0);

        // Random traffic, mostly well-aligned with injected errors
        for (int i = 0; i < 3000; i++) begin
            bit r, v, s;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) != 0);
            if (m_pos == 0) s = ($urandom_range(0, 9) != 0);
            else            s = ($urandom_range(0, 19) == 0);
            cyc(r, v, s, W'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
